// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient decimating FIR. LOAD pops DECIMATION samples, MAC runs one
// complex tap per cycle, WRITE hands the registered result to the downstream FIFO.
module fir_cmplx_decim #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int TAPS        = 20,
  parameter int DECIMATION  = 1,
  parameter int BITS        = 10,
  parameter logic [0:TAPS-1][COEFF_WIDTH-1:0] H_REAL =
    {COEFF_WIDTH'(32'd1 << BITS), {((TAPS - 1) * COEFF_WIDTH){1'b0}}},
  parameter logic [0:TAPS-1][COEFF_WIDTH-1:0] H_IMAG = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      i_in,
  input  logic [DATA_WIDTH-1:0]      q_in,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  input  logic                       coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coeff_addr,
  input  logic [COEFF_WIDTH-1:0]     coeff_real,
  input  logic [COEFF_WIDTH-1:0]     coeff_imag,
  output logic                       coeff_busy,
  output logic [DATA_WIDTH-1:0]      y_real_out,
  output logic [DATA_WIDTH-1:0]      y_imag_out,
  output logic                       out_wr_en,
  input  logic                       out_full
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + TAP_W + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                         state_r, state_next_s;
  logic [DEC_W-1:0]               dec_cnt_r;
  logic [TAP_W-1:0]               tap_r;
  logic signed [DATA_WIDTH-1:0]   x_re_r [TAPS];
  logic signed [DATA_WIDTH-1:0]   x_im_r [TAPS];
  logic signed [COEFF_WIDTH-1:0]  h_re_r [TAPS];
  logic signed [COEFF_WIDTH-1:0]  h_im_r [TAPS];
  logic signed [ACC_W-1:0]        acc_re_r, acc_im_r;
  logic [DATA_WIDTH-1:0]          y_re_r, y_im_r;

  logic                           pop_s, push_s, busy_s;
  logic                           last_pop_s, last_tap_s, addr_ok_s, coeff_we_s;
  logic signed [ACC_W-1:0]        xr_s, xi_s, hr_s, hi_s;
  logic signed [ACC_W-1:0]        prod_re_s, prod_im_s, sum_re_s, sum_im_s;

  assign last_pop_s = (dec_cnt_r == DEC_W'(DECIMATION - 1));
  assign last_tap_s = (tap_r == TAP_W'(TAPS - 1));
  assign addr_ok_s  = ({1'b0, coeff_addr} < (TAP_W + 1)'(TAPS));
  assign coeff_we_s = coeff_wr_en & ~busy_s & ~reset & addr_ok_s;

  assign in_rd_en   = pop_s;
  assign out_wr_en  = push_s;
  assign coeff_busy = busy_s;
  assign y_real_out = y_re_r;
  assign y_imag_out = y_im_r;

  // Next-state and handshake decode; reset forces every strobe low at once.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    busy_s       = 1'b0;
    state_next_s = state_r;
    if (reset) begin
      state_next_s = LOAD;
    end else begin
      case (state_r)
        LOAD: begin
          pop_s = ~in_empty;
          if (pop_s && last_pop_s) state_next_s = MAC;
          else                     state_next_s = LOAD;
        end
        MAC: begin
          busy_s = 1'b1;
          if (last_tap_s) state_next_s = WRITE;
          else            state_next_s = MAC;
        end
        WRITE: begin
          push_s = ~out_full;
          if (push_s) state_next_s = LOAD;
          else        state_next_s = WRITE;
        end
        default: state_next_s = LOAD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= LOAD;
    else       state_r <= state_next_s;
  end

  // One complex product per cycle, operands widened first so nothing can overflow.
  always_comb begin
    xr_s      = ACC_W'(x_re_r[tap_r]);
    xi_s      = ACC_W'(x_im_r[tap_r]);
    hr_s      = ACC_W'(h_re_r[tap_r]);
    hi_s      = ACC_W'(h_im_r[tap_r]);
    prod_re_s = xr_s * hr_s - xi_s * hi_s;
    prod_im_s = xr_s * hi_s + xi_s * hr_s;
    sum_re_s  = acc_re_r + prod_re_s;
    sum_im_s  = acc_im_r + prod_im_s;
  end

  // Sample delay line and decimation counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x_re_r[k] <= '0;
        x_im_r[k] <= '0;
      end
      dec_cnt_r <= '0;
    end else if (pop_s) begin
      x_re_r[0] <= $signed(i_in);
      x_im_r[0] <= $signed(q_in);
      for (int k = 1; k < TAPS; k++) begin
        x_re_r[k] <= x_re_r[k-1];
        x_im_r[k] <= x_im_r[k-1];
      end
      dec_cnt_r <= last_pop_s ? '0 : dec_cnt_r + DEC_W'(1);
    end
  end

  // Tap walk and accumulation; outputs only change when the last tap lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_re_r <= '0;
      acc_im_r <= '0;
      tap_r    <= '0;
      y_re_r   <= '0;
      y_im_r   <= '0;
    end else if (state_r == MAC) begin
      if (last_tap_s) begin
        y_re_r   <= DATA_WIDTH'(sum_re_s >>> BITS);
        y_im_r   <= DATA_WIDTH'(sum_im_s >>> BITS);
        acc_re_r <= '0;
        acc_im_r <= '0;
        tap_r    <= '0;
      end else begin
        acc_re_r <= sum_re_s;
        acc_im_r <= sum_im_s;
        tap_r    <= tap_r + TAP_W'(1);
      end
    end
  end

  // Coefficient bank, reloaded from the parameters on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        h_re_r[k] <= H_REAL[k];
        h_im_r[k] <= H_IMAG[k];
      end
    end else if (coeff_we_s) begin
      h_re_r[coeff_addr] <= $signed(coeff_real);
      h_im_r[coeff_addr] <= $signed(coeff_imag);
    end
  end

endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Bench for fir_cmplx_decim: a sum-of-products model scores every output of the
// default instance; a DECIMATION=4 instance is checked against literal values.
module tb_fir_cmplx_decim;

  localparam int TAPS = 20;
  localparam int BITS = 10;
  localparam int DEC0 = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] i_in, q_in, coeff_real, coeff_imag, y_real_out, y_imag_out;
  logic        in_empty, in_rd_en, coeff_wr_en, coeff_busy, out_wr_en, out_full;
  logic [4:0]  coeff_addr;

  logic [31:0] i_in_d4, q_in_d4, coeff_real_d4, coeff_imag_d4, y_real_d4, y_imag_d4;
  logic        in_empty_d4, in_rd_en_d4, coeff_wr_en_d4, coeff_busy_d4, out_wr_en_d4, out_full_d4;
  logic [4:0]  coeff_addr_d4;

  fir_cmplx_decim dut (
    .clock(clock), .reset(reset), .i_in(i_in), .q_in(q_in), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
    .coeff_real(coeff_real), .coeff_imag(coeff_imag), .coeff_busy(coeff_busy),
    .y_real_out(y_real_out), .y_imag_out(y_imag_out), .out_wr_en(out_wr_en),
    .out_full(out_full)
  );

  fir_cmplx_decim #(.DECIMATION(4)) dut_d4 (
    .clock(clock), .reset(reset), .i_in(i_in_d4), .q_in(q_in_d4), .in_empty(in_empty_d4),
    .in_rd_en(in_rd_en_d4), .coeff_wr_en(coeff_wr_en_d4), .coeff_addr(coeff_addr_d4),
    .coeff_real(coeff_real_d4), .coeff_imag(coeff_imag_d4), .coeff_busy(coeff_busy_d4),
    .y_real_out(y_real_d4), .y_imag_out(y_imag_d4), .out_wr_en(out_wr_en_d4),
    .out_full(out_full_d4)
  );

  typedef struct {
    longint re;
    longint im;
    int     edge_n;
  } exp_t;

  int      compared = 0;
  int      mismatched = 0;
  int      cyc = 0;
  int      out_cnt = 0;
  int      pop_cnt = 0;
  int      pops_d4 = 0;
  bit      stall_mode = 1'b0;
  longint  hist_re [TAPS];
  longint  hist_im [TAPS];
  longint  m_hr [TAPS];
  longint  m_hi [TAPS];
  longint  last_re, last_im;
  longint  outs_re [$];
  longint  outs_im [$];
  longint  outs_d4 [$];
  int      popsat_d4 [$];
  exp_t    exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist_re[k] = 0;
      hist_im[k] = 0;
      m_hr[k]    = 0;
      m_hi[k]    = 0;
    end
    m_hr[0] = longint'(1) << BITS;
    pop_cnt = 0;
    exp_q.delete();
  endtask

  // Filter model: y = sum x[k]*h[k], shifted and truncated to 32 bits.
  task automatic model_pop(input longint re, input longint im);
    longint sr, si;
    exp_t   e;
    for (int k = TAPS - 1; k > 0; k--) begin
      hist_re[k] = hist_re[k-1];
      hist_im[k] = hist_im[k-1];
    end
    hist_re[0] = re;
    hist_im[0] = im;
    pop_cnt++;
    if (pop_cnt == DEC0) begin
      pop_cnt = 0;
      sr = 0;
      si = 0;
      for (int k = 0; k < TAPS; k++) begin
        sr += hist_re[k] * m_hr[k] - hist_im[k] * m_hi[k];
        si += hist_re[k] * m_hi[k] + hist_im[k] * m_hr[k];
      end
      e.re     = longint'(int'(sr >>> BITS));
      e.im     = longint'(int'(si >>> BITS));
      e.edge_n = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Compare process for the default instance, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      check("rst_in_rd_en", longint'(in_rd_en), 0);
      check("rst_out_wr_en", longint'(out_wr_en), 0);
      check("rst_coeff_busy", longint'(coeff_busy), 0);
      model_reset();
    end else begin
      check("rd_wr_overlap", longint'(in_rd_en & out_wr_en), 0);
      if (coeff_wr_en && !coeff_busy && coeff_addr < 5'(TAPS)) begin
        m_hr[coeff_addr] = longint'($signed(coeff_real));
        m_hi[coeff_addr] = longint'($signed(coeff_imag));
      end
      if (in_rd_en) model_pop(longint'($signed(i_in)), longint'($signed(q_in)));
      if (out_wr_en) begin
        out_cnt++;
        last_re = longint'($signed(y_real_out));
        last_im = longint'($signed(y_imag_out));
        outs_re.push_back(last_re);
        outs_im.push_back(last_im);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got (%0d,%0d), expected no output", last_re, last_im);
        end else begin
          e = exp_q.pop_front();
          check("y_real", last_re, e.re);
          check("y_imag", last_im, e.im);
          if (!stall_mode) check("latency", longint'(cyc + 1 - e.edge_n), longint'(TAPS + 1));
        end
      end
    end
  end

  // Recorder for the decimating instance.
  always @(negedge clock) begin
    if (!reset) begin
      if (in_rd_en_d4) pops_d4++;
      if (out_wr_en_d4) begin
        outs_d4.push_back(longint'($signed(y_real_d4)));
        popsat_d4.push_back(pops_d4);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic offer(input longint re, input longint im);
    i_in     = 32'(re);
    q_in     = 32'(im);
    in_empty = 1'b0;
  endtask

  task automatic wait_pop();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (in_rd_en) done = 1'b1;
    end
    check("pop_timeout", longint'(done), 1);
    @(posedge clock);
    #1;
    in_empty = 1'b1;
  endtask

  task automatic send(input longint re, input longint im);
    offer(re, im);
    wait_pop();
  endtask

  task automatic wait_outs(input int target);
    for (int t = 0; t < 400 && out_cnt < target; t++) @(negedge clock);
    check("out_timeout", longint'(out_cnt >= target), 1);
    @(posedge clock);
    #1;
  endtask

  task automatic wcoeff(input int addr, input longint re, input longint im);
    coeff_addr  = 5'(addr);
    coeff_real  = 32'(re);
    coeff_imag  = 32'(im);
    coeff_wr_en = 1'b1;
    tick(1);
    coeff_wr_en = 1'b0;
  endtask

  task automatic send_d4(input longint re);
    bit done = 1'b0;
    i_in_d4     = 32'(re);
    q_in_d4     = 32'd0;
    in_empty_d4 = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (in_rd_en_d4) done = 1'b1;
    end
    check("pop_timeout_d4", longint'(done), 1);
    @(posedge clock);
    #1;
    in_empty_d4 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    i_in = 32'd0; q_in = 32'd0; in_empty = 1'b1; out_full = 1'b0;
    coeff_wr_en = 1'b0; coeff_addr = 5'd0; coeff_real = 32'd0; coeff_imag = 32'd0;
    i_in_d4 = 32'd0; q_in_d4 = 32'd0; in_empty_d4 = 1'b1; out_full_d4 = 1'b0;
    coeff_wr_en_d4 = 1'b0; coeff_addr_d4 = 5'd0; coeff_real_d4 = 32'd0; coeff_imag_d4 = 32'd0;
    tick(3);
    reset = 1'b0;
    check("rst_y_real", longint'($signed(y_real_out)), 0);
    check("rst_y_imag", longint'($signed(y_imag_out)), 0);

    // Identity filter passes the sample straight through.
    send(100, -50);
    wait_outs(1);
    check("ident_re", last_re, 100);
    check("ident_im", last_im, -50);

    // Ramp coefficients against an impulse give 1..20 then 0.
    do_reset(1);
    for (int k = 0; k < TAPS; k++) wcoeff(k, 1024 * (k + 1), 0);
    base = out_cnt;
    send(1, 0);
    for (int k = 0; k < TAPS; k++) send(0, 0);
    wait_outs(base + TAPS + 1);
    for (int k = 0; k <= TAPS; k++) begin
      check("impulse_re", outs_re[base + k], (k < TAPS) ? longint'(k + 1) : 0);
      check("impulse_im", outs_im[base + k], 0);
    end

    // Pure imaginary tap rotates (3,4) to (-4,3).
    for (int k = 0; k < TAPS; k++) wcoeff(k, 0, 0);
    wcoeff(0, 0, 1024);
    base = out_cnt;
    send(3, 4);
    wait_outs(base + 1);
    check("rot_re", last_re, -4);
    check("rot_im", last_im, 3);

    // Reset mid-MAC zeroes outputs and restores default coefficients.
    wcoeff(0, 2048, 0);
    send(7, 0);
    tick(5);
    check("busy_in_mac", longint'(coeff_busy), 1);
    do_reset(1);
    check("midrst_y_real", longint'($signed(y_real_out)), 0);
    check("midrst_y_imag", longint'($signed(y_imag_out)), 0);
    base = out_cnt;
    send(5, 5);
    wait_outs(base + 1);
    check("postrst_re", last_re, 5);
    check("postrst_im", last_im, 5);

    // A coefficient write during MAC must be dropped.
    base = out_cnt;
    send(2, 0);
    tick(2);
    check("busy_mac2", longint'(coeff_busy), 1);
    wcoeff(0, 8192, 0);
    wait_outs(base + 1);
    check("busywr_re", last_re, 2);

    // Downstream full for ten cycles in WRITE: everything holds.
    out_full   = 1'b1;
    stall_mode = 1'b1;
    base = out_cnt;
    send(9, -9);
    offer(11, 0);
    tick(TAPS + 2);
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      check("stall_rd_en", longint'(in_rd_en), 0);
      check("stall_wr_en", longint'(out_wr_en), 0);
      check("stall_y_real", longint'($signed(y_real_out)), 9);
      check("stall_y_imag", longint'($signed(y_imag_out)), -9);
    end
    @(posedge clock);
    #1;
    out_full = 1'b0;
    wait_outs(base + 1);
    check("stall_one_push", longint'(out_cnt), longint'(base + 1));
    stall_mode = 1'b0;
    wait_pop();
    wait_outs(base + 2);
    check("after_stall_re", last_re, 11);

    // Decimate by four: ramp 0..11 yields 3, 7, 11.
    for (int v = 0; v < 12; v++) send_d4(v);
    for (int t = 0; t < 400 && outs_d4.size() < 3; t++) @(negedge clock);
    check("d4_count", longint'(outs_d4.size()), 3);
    for (int k = 0; k < 3 && k < outs_d4.size(); k++) begin
      check("d4_value", outs_d4[k], longint'(4 * k + 3));
      check("d4_pops", longint'(popsat_d4[k]), longint'(4 * (k + 1)));
    end

    tick(TAPS + 5);
    check("pending_outputs", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
